// File: rtl/cross_bar_slave_sched.sv
// cross_bar_slave_sched: round-robin owner scheduler in front of one slave port.
// Define CROSS_BAR_TIMEOUT_EN to abort transactions the slave never acks.
package cross_bar_pkg;
  localparam int MASTER_N = 4;
endpackage

module cross_bar_slave_sched
  import cross_bar_pkg::*;
#(
  parameter int LOCK_MAX    = 4,
  parameter int TIMEOUT_CYC = 16,
  localparam int IDX_W      = $clog2(MASTER_N)
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic [MASTER_N-1:0] req,
  input  logic [MASTER_N-1:0] lock,
  output logic [MASTER_N-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                slave_req,
  input  logic                slave_ack,
  output logic [MASTER_N-1:0] master_ack,
  output logic [MASTER_N-1:0] master_err,
  output logic                busy
);

  localparam int BW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(LOCK_MAX - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MASTER_N - 1);

  if (MASTER_N < 2 || LOCK_MAX < 1 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("cross_bar_slave_sched: illegal parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [IDX_W-1:0]    owner_q;
  logic [IDX_W-1:0]    owner_d;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    ptr_d;
  logic [IDX_W-1:0]    nxt_ptr;
  logic [BW-1:0]       burst_q;
  logic [BW-1:0]       burst_d;
  logic                keep_q;
  logic                keep_d;
  logic [MASTER_N-1:0] grant_d;
  logic [MASTER_N-1:0] ack_d;
  logic [MASTER_N-1:0] owner_oh;
  logic [IDX_W:0]      pick_idle;
  logic [IDX_W:0]      pick_gap;

  // Returns {found, index} of the first requester at or after p.
  function automatic logic [IDX_W:0] pick(
    input logic [MASTER_N-1:0] r,
    input logic [IDX_W-1:0]    p
  );
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] j;
    int               s;
    res = '0;
    for (int k = MASTER_N - 1; k >= 0; k--) begin
      s = int'(p) + k;
      if (s >= MASTER_N) s = s - MASTER_N;
      j = IDX_W'(s);
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  assign nxt_ptr   = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
  assign owner_oh  = MASTER_N'(1) << owner_q;
  assign pick_idle = pick(req, ptr_q);
  assign pick_gap  = pick(req, nxt_ptr);
  assign busy      = (state_q != IDLE);

`ifdef CROSS_BAR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0]       wait_q;
  logic                to_hit;
  logic [MASTER_N-1:0] err_d;

  assign to_hit = (wait_q == WAIT_LAST);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wait_q     <= '0;
      master_err <= '0;
    end else begin
      wait_q     <= (state_q == BUSY) ? wait_q + 1'b1 : '0;
      master_err <= err_d;
    end
  end
`else
  assign master_err = '0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    keep_d  = keep_q;
    grant_d = grant;
    ack_d   = '0;
`ifdef CROSS_BAR_TIMEOUT_EN
    err_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_idle[IDX_W]) begin
          owner_d = pick_idle[IDX_W-1:0];
          grant_d = MASTER_N'(1) << owner_d;
          burst_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (slave_ack) begin
          ack_d   = owner_oh;
          keep_d  = lock[owner_q] & req[owner_q]
                  & (burst_q < BURST_LAST);
          state_d = GAP;
          if (!keep_d) grant_d = '0;
        end
`ifdef CROSS_BAR_TIMEOUT_EN
        else if (to_hit) begin
          err_d   = owner_oh;
          keep_d  = 1'b0;
          grant_d = '0;
          state_d = GAP;
        end
`endif
      end
      GAP: begin
        if (keep_q) begin
          burst_d = burst_q + 1'b1;
          state_d = BUSY;
        end else begin
          // Released owner drops to lowest priority.
          ptr_d = nxt_ptr;
          if (pick_gap[IDX_W]) begin
            owner_d = pick_gap[IDX_W-1:0];
            grant_d = MASTER_N'(1) << owner_d;
            burst_d = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      burst_q    <= '0;
      keep_q     <= 1'b0;
      grant      <= '0;
      grant_idx  <= '0;
      slave_req  <= 1'b0;
      master_ack <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      burst_q    <= burst_d;
      keep_q     <= keep_d;
      grant      <= grant_d;
      grant_idx  <= (|grant_d) ? owner_d : '0;
      slave_req  <= (state_d == BUSY);
      master_ack <= ack_d;
    end
  end

endmodule

// File: tb/tb_cross_bar_slave_sched.sv
// Directed bench for cross_bar_slave_sched (MASTER_N=4, LOCK_MAX=4).
// Exercises the timeout path when CROSS_BAR_TIMEOUT_EN is defined.
module tb_cross_bar_slave_sched;
  import cross_bar_pkg::*;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] lock = '0;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       slave_req;
  logic       slave_ack = 1'b0;
  logic [3:0] master_ack;
  logic [3:0] master_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cross_bar_slave_sched #(
    .LOCK_MAX   (4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .req       (req),
    .lock      (lock),
    .grant     (grant),
    .grant_idx (grant_idx),
    .slave_req (slave_req),
    .slave_ack (slave_ack),
    .master_ack(master_ack),
    .master_err(master_err),
    .busy      (busy)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    aresetn = 1'b0;
    req = '0;
    lock = '0;
    slave_ack = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL reset_grant got=%b exp=0000", grant);
    end
    checks++;
    if (grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_idx got=%0d exp=0", grant_idx);
    end
    checks++;
    if (slave_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_sreq got=%b exp=0", slave_req);
    end
    checks++;
    if (master_ack !== 4'b0000 || master_err !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ack_err got=%b/%b exp=0000/0000",
               master_ack, master_err);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_i [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (grant !== exp_g[k] || grant_idx !== exp_i[k]) begin
        errors++;
        $display("FAIL rr_grant k=%0d got=%b/%0d exp=%b/%0d",
                 k, grant, grant_idx, exp_g[k], exp_i[k]);
      end
      checks++;
      if (slave_req !== 1'b1) begin
        errors++;
        $display("FAIL rr_sreq k=%0d got=%b exp=1", k, slave_req);
      end
      tick();
      tick();
      slave_ack = 1'b1;
      tick();
      slave_ack = 1'b0;
      checks++;
      if (master_ack !== exp_g[k]) begin
        errors++;
        $display("FAIL rr_ack k=%0d got=%b exp=%b", k, master_ack, exp_g[k]);
      end
      checks++;
      if (slave_req !== 1'b0 || grant !== 4'b0000) begin
        errors++;
        $display("FAIL rr_gap k=%0d got sreq=%b grant=%b exp 0/0000",
                 k, slave_req, grant);
      end
      if (k == 4) req = '0;
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_single;
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
      errors++;
      $display("FAIL single_grant got=%b/%0d exp=0100/2", grant, grant_idx);
    end
    checks++;
    if (slave_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_sreq got=%b/%b exp=1/1", slave_req, busy);
    end
    req = '0;
    tick();
    checks++;
    if (slave_req !== 1'b1 || grant !== 4'b0100) begin
      errors++;
      $display("FAIL single_drop got=%b/%b exp=1/0100", slave_req, grant);
    end
    tick();
    slave_ack = 1'b1;
    tick();
    slave_ack = 1'b0;
    checks++;
    if (master_ack !== 4'b0100) begin
      errors++;
      $display("FAIL single_ack got=%b exp=0100", master_ack);
    end
    checks++;
    if (slave_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gap got=%b/%b exp=0/1", slave_req, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000 || master_ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_end got=%b/%b/%b exp=0/0000/0000",
               busy, grant, master_ack);
    end
  endtask

  task automatic test_stray_ack;
    slave_ack = 1'b1;
    tick();
    slave_ack = 1'b0;
    checks++;
    if (master_ack !== 4'b0000 || busy !== 1'b0 || slave_req !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack got=%b/%b/%b exp=0000/0/0",
               master_ack, busy, slave_req);
    end
  endtask

  task automatic test_lock;
    logic [3:0] exp_gap [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000};
    do_reset();
    req = 4'b0010;
    lock = 4'b0010;
    tick();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (grant !== 4'b0010 || slave_req !== 1'b1) begin
        errors++;
        $display("FAIL lock_busy k=%0d got=%b/%b exp=0010/1",
                 k, grant, slave_req);
      end
      tick();
      slave_ack = 1'b1;
      tick();
      slave_ack = 1'b0;
      checks++;
      if (master_ack !== 4'b0010 || slave_req !== 1'b0) begin
        errors++;
        $display("FAIL lock_ack k=%0d got=%b/%b exp=0010/0",
                 k, master_ack, slave_req);
      end
      checks++;
      if (grant !== exp_gap[k]) begin
        errors++;
        $display("FAIL lock_gap k=%0d got=%b exp=%b", k, grant, exp_gap[k]);
      end
      tick();
    end
    checks++;
    if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
      errors++;
      $display("FAIL lock_handover got=%b/%0d exp=0100/2", grant, grant_idx);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    aresetn = 1'b0;
    req = '0;
    #1;
    checks++;
    if (grant !== 4'b0000 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL mid_grant got=%b/%0d exp=0000/0", grant, grant_idx);
    end
    checks++;
    if (slave_req !== 1'b0 || busy !== 1'b0 || master_ack !== 4'b0000) begin
      errors++;
      $display("FAIL mid_out got=%b/%b/%b exp=0/0/0000",
               slave_req, busy, master_ack);
    end
    tick();
    aresetn = 1'b1;
    req = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000 || grant_idx !== 2'd3 || slave_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_regrant got=%b/%0d/%b exp=1000/3/1",
               grant, grant_idx, slave_req);
    end
  endtask

`ifdef CROSS_BAR_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    req = 4'b0101;
    lock = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL to_grant got=%b exp=0001", grant);
    end
    repeat (15) tick();
    checks++;
    if (slave_req !== 1'b1 || master_err !== 4'b0000) begin
      errors++;
      $display("FAIL to_wait got=%b/%b exp=1/0000", slave_req, master_err);
    end
    tick();
    checks++;
    if (master_err !== 4'b0001 || master_ack !== 4'b0000) begin
      errors++;
      $display("FAIL to_err got=%b/%b exp=0001/0000", master_err, master_ack);
    end
    checks++;
    if (grant !== 4'b0000 || slave_req !== 1'b0) begin
      errors++;
      $display("FAIL to_gap got=%b/%b exp=0000/0", grant, slave_req);
    end
    tick();
    req = 4'b0100;
    checks++;
    if (grant !== 4'b0100 || master_err !== 4'b0000) begin
      errors++;
      $display("FAIL to_next got=%b/%b exp=0100/0000", grant, master_err);
    end
    repeat (15) tick();
    slave_ack = 1'b1;
    tick();
    slave_ack = 1'b0;
    checks++;
    if (master_ack !== 4'b0100 || master_err !== 4'b0000) begin
      errors++;
      $display("FAIL to_lastack got=%b/%b exp=0100/0000",
               master_ack, master_err);
    end
  endtask
`else
  task automatic test_no_timeout;
    int bad;
    do_reset();
    req = 4'b0001;
    tick();
    bad = 0;
    repeat (100) begin
      if (grant !== 4'b0001 || slave_req !== 1'b1 || master_err !== 4'b0000)
        bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold bad_cycles got=%0d exp=0", bad);
    end
    slave_ack = 1'b1;
    tick();
    slave_ack = 1'b0;
    checks++;
    if (master_ack !== 4'b0001 || master_err !== 4'b0000) begin
      errors++;
      $display("FAIL hold_ack got=%b/%b exp=0001/0000", master_ack, master_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_stray_ack();
    test_lock();
    test_reset_mid();
`ifdef CROSS_BAR_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cross_bar_slave_sched.md
# cross_bar_slave_sched

Per-slave transaction scheduler for the cross bar. It shares one slave port among MASTER_N masters by round-robin arbitration. Ownership is held for a whole request/acknowledge transaction, and can be held for a bounded run of locked back-to-back transactions. It drives the slave-side request and routes the slave's acknowledge back to the owning master; one instance sits in front of each slave port.

## Interface
- MASTER_N, cross_bar_pkg::MASTER_N (localparam, ≥2): number of masters.
- LOCK_MAX, 4: max consecutive transactions per ownership under lock (≥1).
- TIMEOUT_CYC, 16: cycles a transaction waits for slave_ack before abort (≥2; used only with CROSS_BAR_TIMEOUT_EN).
- IDX_W, $clog2(MASTER_N) (localparam): owner index width.
- clk  in  1  single clock, all logic on posedge.
- aresetn  in  1  asynchronous active-low reset.
- req  in  MASTER_N  per-master request; held high until that master's master_ack or master_err.
- lock  in  MASTER_N  per-master lock; sampled on the ack cycle of the owner's transaction.
- grant  out  MASTER_N  one-hot owner, or all zero; registered.
- grant_idx  out  IDX_W  binary index of owner; 0 when grant is 0.
- slave_req  out  1  transaction request to the slave; registered.
- slave_ack  in  1  single-cycle completion pulse from the slave.
- master_ack  out  MASTER_N  one-cycle completion pulse to the owner; registered.
- master_err  out  MASTER_N  one-cycle abort pulse to the owner (timeout); registered.
- busy  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, BUSY, GAP.
- IDLE: if |req, pick a winner, load the owner and go to BUSY; otherwise stay.
- BUSY: slave_req=1 and grant=owner.
  - slave_ack=1: master_ack[owner] pulses next cycle; go to GAP.
  - keep flag is registered as lock[owner] & req[owner] & (burst_cnt < LOCK_MAX-1).
- GAP: slave_req=0.
  - keep=1: grant stays on the owner, burst_cnt+1, go to BUSY.
  - keep=0: grant=0, advance the pointer past the owner, then arbitrate. A winner gives BUSY with burst_cnt=0; no request gives IDLE.
- Arbitration: rotating priority, starting at the index after the last released owner, wrapping modulo MASTER_N. After reset, master 0 has highest priority.
- req of the owner dropping in BUSY is ignored; the transaction completes normally.
- slave_ack outside BUSY is ignored.
- burst_cnt is IDX-independent and saturates by construction at LOCK_MAX-1. With LOCK_MAX=1, lock has no effect.
- Reset (any time, including mid-transaction): grant=0, grant_idx=0, slave_req=0, master_ack=0, master_err=0, busy=0, pointer=master 0 first, FSM=IDLE, counters 0.

## Timing
- Request latency: req[i] sampled high in IDLE at cycle t gives grant[i] and slave_req high from cycle t+1.
- Completion: slave_ack in cycle n gives master_ack[owner]=1 and slave_req=0 in cycle n+1 (GAP).
- Locked continuation: slave_req high again in cycle n+2, same owner.
- Handover: a new owner's grant and slave_req appear in cycle n+2. grant is 0 in cycle n+1.
- Idle gap: minimum one cycle of slave_req=0 between any two transactions.
- master_ack and master_err are never high together. At most one bit of each is set.

## Configuration
- CROSS_BAR_TIMEOUT_EN defined:
  - A wait counter clears on BUSY entry and increments each BUSY cycle.
  - If the counter reaches TIMEOUT_CYC-1 and slave_ack=0, the transaction aborts: master_err[owner] pulses next cycle, lock is ignored (keep=0), and the FSM goes to GAP.
  - slave_ack in the timeout cycle wins: ack path, no error.
- Not defined: no counter, BUSY waits indefinitely, master_err tied to 0.

## Test plan
Run with MASTER_N=4, LOCK_MAX=4, TIMEOUT_CYC=16.
- Reset release with req=4'b1111 and slave_ack two cycles after each slave_req rise -> grants in order 0,1,2,3,0. One master_ack per grant. One-cycle slave_req gap each time.
- req=4'b0100 only from IDLE at cycle t -> grant=4'b0100, grant_idx=2 and slave_req=1 at t+1. With ack at t+3: master_ack=4'b0100 at t+4, busy=0 at t+5.
- Master 1 holds lock=1 and req=1 while masters 0, 2, 3 request -> exactly 4 consecutive master 1 transactions, then grant moves to master 2.
- Reset asserted mid-BUSY -> all outputs 0 immediately. After release, req=4'b1000 gets grant from master 0's priority position, i.e. grant=4'b1000.
- With CROSS_BAR_TIMEOUT_EN and no slave_ack -> master_err[owner] pulses 16 cycles after slave_req rose, lock is ignored, next requester is granted. Ack on cycle 16 gives master_ack, no master_err.
- Without the macro and ack withheld 100 cycles -> grant and slave_req held throughout, master_err stays 0.
